neuron_mac_master: RTL

//  FPGA-side engine behind the HPS control conduit. On start it reads kernel_size^2 image words and weight words
//  as an Avalon-MM master on the img and weight ports, multiply-accumulates them, and reports result and done.

---
 rtl/neuron_pkg.sv | 8 +
 rtl/neuron_mac_unit.sv | 30 +++
 rtl/neuron_mac_master.sv | 134 +++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and widths for the neuron MAC engine.
package neuron_pkg;
  localparam int DATA_W = 32;
  localparam int OPND_W = 16;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MAC, S_DONE} state_e;
endpackage

// File: rtl/neuron_mac_unit.sv
// Signed 16x16 multiply feeding a wrapping 32-bit accumulator.
// sum is the value the accumulator takes if en is asserted this cycle.
module neuron_mac_unit
  import neuron_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [DATA_W-1:0] sum
);
  logic signed [DATA_W-1:0] prod;
  logic [DATA_W-1:0] acc_q, acc_d;

  assign prod = $signed(a) * $signed(b);
  assign sum  = acc_q + DATA_W'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
endmodule

// File: rtl/neuron_mac_master.sv
// Control FSM plus two independent Avalon-MM read channels (image, weight)
// that fetch one operand pair per element and accumulate K*K products.
module neuron_mac_master
  import neuron_pkg::*;
#(
  parameter logic [DATA_W-1:0] WEI_BASE = 32'h0000_0000,
  parameter bit                RELU     = 1'b1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              control_start,
  input  logic              control_clear,
  input  logic [DATA_W-1:0] control_base_addr,
  input  logic [7:0]        control_kernel_size,
  output logic              control_done,
  output logic [DATA_W-1:0] control_result,
  output logic [DATA_W-1:0] control_addr_img,
  output logic [DATA_W-1:0] control_addr_wei,
  output logic              img_read,
  output logic              img_write,
  output logic [DATA_W-1:0] img_address,
  output logic [DATA_W-1:0] img_writedata,
  input  logic [DATA_W-1:0] img_readdata,
  input  logic              img_waitrequest,
  output logic              weight_read,
  output logic              weight_write,
  output logic [DATA_W-1:0] weight_address,
  output logic [DATA_W-1:0] weight_writedata,
  input  logic [DATA_W-1:0] weight_readdata,
  input  logic              weight_waitrequest
);
  state_e state_q, state_d;
  logic [DATA_W-1:0] base_q, base_d, img_adr_q, img_adr_d, wei_adr_q, wei_adr_d;
  logic [DATA_W-1:0] addr_img_q, addr_img_d, addr_wei_q, addr_wei_d, result_q, result_d;
  logic [CNT_W-1:0]  n_q, n_d, i_q, i_d, i_nxt, n_new;
  logic [OPND_W-1:0] img_dat_q, img_dat_d, wei_dat_q, wei_dat_d;
  logic abort_q, abort_d, abort_now, done_q, done_d;
  logic img_rd_q, img_rd_d, wei_rd_q, wei_rd_d, img_got_q, img_got_d, wei_got_q, wei_got_d;
  logic img_cap, wei_cap, acc_clr, acc_en;
  logic [DATA_W-1:0] acc_sum;
  // Operands are 16-bit; the upper halves of the read buses are don't-care.
  logic unused_hi;
  assign unused_hi = ^{img_readdata[DATA_W-1:OPND_W], weight_readdata[DATA_W-1:OPND_W]};

  neuron_mac_unit u_mac (
    .clk(clk_clk), .rst(reset_reset), .clr(acc_clr), .en(acc_en),
    .a(img_dat_q), .b(wei_dat_q), .sum(acc_sum)
  );

  always_comb begin
    state_d = state_q;  base_d = base_q;  n_d = n_q;  i_d = i_q;
    abort_d = abort_q;  done_d = done_q;  result_d = result_q;
    img_rd_d = img_rd_q;  wei_rd_d = wei_rd_q;  img_got_d = img_got_q;  wei_got_d = wei_got_q;
    img_dat_d = img_dat_q;  wei_dat_d = wei_dat_q;  img_adr_d = img_adr_q;  wei_adr_d = wei_adr_q;
    addr_img_d = addr_img_q;  addr_wei_d = addr_wei_q;
    acc_clr = 1'b0;  acc_en = 1'b0;
    img_cap   = img_rd_q && !img_waitrequest;
    wei_cap   = wei_rd_q && !weight_waitrequest;
    i_nxt     = i_q + 1'b1;
    n_new     = CNT_W'(control_kernel_size) * CNT_W'(control_kernel_size);
    abort_now = abort_q || control_clear;
    case (state_q)
      S_IDLE: if (control_start) begin
        base_d = control_base_addr;  n_d = n_new;  i_d = '0;  abort_d = 1'b0;  acc_clr = 1'b1;
        if (n_new == '0) begin
          state_d = S_DONE;  done_d = 1'b1;  result_d = '0;
        end else begin
          state_d = S_FETCH;  img_rd_d = 1'b1;  wei_rd_d = 1'b1;
          img_got_d = 1'b0;  wei_got_d = 1'b0;
          img_adr_d = control_base_addr;  wei_adr_d = WEI_BASE;
        end
      end
      S_FETCH: begin
        abort_d = abort_now;
        if (img_cap) begin
          img_rd_d = 1'b0;  img_got_d = 1'b1;  img_dat_d = img_readdata[OPND_W-1:0];  addr_img_d = img_adr_q;
        end
        if (wei_cap) begin
          wei_rd_d = 1'b0;  wei_got_d = 1'b1;  wei_dat_d = weight_readdata[OPND_W-1:0];  addr_wei_d = wei_adr_q;
        end
        // Abort only takes effect once neither channel has a read outstanding.
        if ((img_got_q || img_cap) && (wei_got_q || wei_cap))
          state_d = abort_now ? S_IDLE : S_MAC;
      end
      S_MAC: begin
        if (abort_now) begin
          state_d = S_IDLE;
        end else begin
          acc_en = 1'b1;  i_d = i_nxt;
          if (i_nxt == n_q) begin
            state_d = S_DONE;  done_d = 1'b1;
            result_d = (RELU && acc_sum[DATA_W-1]) ? '0 : acc_sum;
          end else begin
            state_d = S_FETCH;  img_rd_d = 1'b1;  wei_rd_d = 1'b1;
            img_got_d = 1'b0;  wei_got_d = 1'b0;
            img_adr_d = base_q + DATA_W'({i_nxt, 2'b00});
            wei_adr_d = WEI_BASE + DATA_W'({i_nxt, 2'b00});
          end
        end
      end
      S_DONE: if (control_clear) begin
        state_d = S_IDLE;  done_d = 1'b0;  result_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;  base_q <= '0;  n_q <= '0;  i_q <= '0;  abort_q <= 1'b0;
      done_q <= 1'b0;  result_q <= '0;  img_rd_q <= 1'b0;  wei_rd_q <= 1'b0;
      img_got_q <= 1'b0;  wei_got_q <= 1'b0;  img_dat_q <= '0;  wei_dat_q <= '0;
      img_adr_q <= '0;  wei_adr_q <= '0;  addr_img_q <= '0;  addr_wei_q <= '0;
    end else begin
      state_q <= state_d;  base_q <= base_d;  n_q <= n_d;  i_q <= i_d;  abort_q <= abort_d;
      done_q <= done_d;  result_q <= result_d;  img_rd_q <= img_rd_d;  wei_rd_q <= wei_rd_d;
      img_got_q <= img_got_d;  wei_got_q <= wei_got_d;  img_dat_q <= img_dat_d;  wei_dat_q <= wei_dat_d;
      img_adr_q <= img_adr_d;  wei_adr_q <= wei_adr_d;  addr_img_q <= addr_img_d;  addr_wei_q <= addr_wei_d;
    end
  end

  assign control_done     = done_q;
  assign control_result   = result_q;
  assign control_addr_img = addr_img_q;
  assign control_addr_wei = addr_wei_q;
  assign img_read         = img_rd_q;
  assign img_address      = img_adr_q;
  assign img_write        = 1'b0;
  assign img_writedata    = '0;
  assign weight_read      = wei_rd_q;
  assign weight_address   = wei_adr_q;
  assign weight_write     = 1'b0;
  assign weight_writedata = '0;
endmodule
